// File: rtl/piece_collision.sv
// Sequential tetromino collision checker: walks the enabled cells of a piece in index
// order, bounds-checks each one and reads its board colour word, stopping at the first hit.
module piece_collision #(
   parameter int BOARD_W   = 10,
   parameter int BOARD_H   = 20,
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int OFF_W     = 2,
   parameter int NUM_CELLS = 4,
   parameter int ADDR_W    = 8,
   parameter int COLOUR_W  = 6,
   parameter int RAM_LAT   = 1
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           start,
   input  logic [X_W-1:0]                 base_x,
   input  logic [Y_W-1:0]                 base_y,
   input  logic [NUM_CELLS*2*OFF_W-1:0]   offsets,
   input  logic [NUM_CELLS-1:0]           cell_en,
   input  logic [COLOUR_W-1:0]            ram_q,
   output logic [ADDR_W-1:0]              ram_addr,
   output logic                           ram_rd,
   output logic                           busy,
   output logic                           done,
   output logic                           collision,
   output logic                           out_of_bounds,
   output logic [$clog2(NUM_CELLS)-1:0]   hit_index
);

   localparam int IDX_W  = $clog2(NUM_CELLS);
   localparam int CELL_W = 2*OFF_W;
   localparam int OFFS_W = NUM_CELLS*CELL_W;
   localparam int WC_W   = $clog2(RAM_LAT+1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS-1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

   // Cell coordinates are one bit wider than the base so a large offset cannot wrap back on-board.
   function automatic logic [X_W:0] f_cx(input logic [X_W-1:0] bx, input logic [OFFS_W-1:0] offs,
                                         input logic [IDX_W-1:0] idx);
      return {1'b0, bx} + (X_W+1)'(offs[idx*CELL_W +: OFF_W]);
   endfunction

   function automatic logic [Y_W:0] f_cy(input logic [Y_W-1:0] by, input logic [OFFS_W-1:0] offs,
                                         input logic [IDX_W-1:0] idx);
      return {1'b0, by} + (Y_W+1)'(offs[idx*CELL_W+OFF_W +: OFF_W]);
   endfunction

   function automatic logic f_oob(input logic [X_W:0] cx, input logic [Y_W:0] cy);
      return (32'(cx) >= 32'(BOARD_W)) || (32'(cy) >= 32'(BOARD_H));
   endfunction

   function automatic logic [ADDR_W-1:0] f_addr(input logic [X_W:0] cx, input logic [Y_W:0] cy);
      return ADDR_W'(32'(cy) * 32'(BOARD_W) + 32'(cx));
   endfunction

   state_t                 r_state;
   logic [X_W-1:0]         r_bx;
   logic [Y_W-1:0]         r_by;
   logic [OFFS_W-1:0]      r_offs;
   logic [NUM_CELLS-1:0]   r_en;
   logic [IDX_W-1:0]       r_idx;
   logic [WC_W-1:0]        r_wcnt;
   logic [ADDR_W-1:0]      r_ram_addr;
   logic                   r_ram_rd;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_coll;
   logic                   r_oob;
   logic [IDX_W-1:0]       r_hit;

   logic                   w_idle;
   logic [X_W-1:0]         w_src_bx;
   logic [Y_W-1:0]         w_src_by;
   logic [OFFS_W-1:0]      w_src_offs;
   logic [NUM_CELLS-1:0]   w_src_en;
   logic [IDX_W-1:0]       w_src_idx;
   logic [X_W:0]           w_nxt_cx;
   logic [Y_W:0]           w_nxt_cy;
   logic                   w_nxt_rd;
   logic [ADDR_W-1:0]      w_nxt_addr;
   logic                   w_cur_en;
   logic                   w_cur_oob;
   logic                   w_adv;
   logic                   w_launch;

   // The read strobe is registered, so the cell about to enter ISSUE is evaluated one cycle early:
   // straight from the inputs when starting, else from the latched piece at the next index.
   always_comb begin
      w_idle     = (r_state == S_IDLE);
      w_src_bx   = w_idle ? base_x  : r_bx;
      w_src_by   = w_idle ? base_y  : r_by;
      w_src_offs = w_idle ? offsets : r_offs;
      w_src_en   = w_idle ? cell_en : r_en;
      w_src_idx  = w_idle ? '0      : r_idx + IDX_W'(1);
      w_nxt_cx   = f_cx(w_src_bx, w_src_offs, w_src_idx);
      w_nxt_cy   = f_cy(w_src_by, w_src_offs, w_src_idx);
      w_nxt_rd   = w_src_en[w_src_idx] & ~f_oob(w_nxt_cx, w_nxt_cy);
      w_nxt_addr = f_addr(w_nxt_cx, w_nxt_cy);
      w_cur_en   = r_en[r_idx];
      w_cur_oob  = f_oob(f_cx(r_bx, r_offs, r_idx), f_cy(r_by, r_offs, r_idx));
      w_adv      = ((r_state == S_ISSUE) && !w_cur_en) ||
                   ((r_state == S_WAIT) && (r_wcnt == '0) && (ram_q == '0));
      w_launch   = (w_idle && start) || (w_adv && (r_idx != LAST_IDX));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_bx       <= '0;
         r_by       <= '0;
         r_offs     <= '0;
         r_en       <= '0;
         r_idx      <= '0;
         r_wcnt     <= '0;
         r_ram_addr <= '0;
         r_ram_rd   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_coll     <= 1'b0;
         r_oob      <= 1'b0;
         r_hit      <= '0;
      end else begin
         r_done   <= 1'b0;
         r_ram_rd <= 1'b0;
         if (w_launch) begin
            r_ram_rd <= w_nxt_rd;
            if (w_nxt_rd) r_ram_addr <= w_nxt_addr;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_bx    <= base_x;
                  r_by    <= base_y;
                  r_offs  <= offsets;
                  r_en    <= cell_en;
                  r_idx   <= '0;
                  r_coll  <= 1'b0;
                  r_oob   <= 1'b0;
                  r_hit   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_cur_en) begin
                  if (w_cur_oob) begin
                     r_coll  <= 1'b1;
                     r_oob   <= 1'b1;
                     r_hit   <= r_idx;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_FIN;
                  end else begin
                     r_wcnt  <= WC_W'(RAM_LAT-1);
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (r_wcnt != '0) begin
                  r_wcnt <= r_wcnt - WC_W'(1);
               end else if (ram_q != '0) begin
                  r_coll  <= 1'b1;
                  r_hit   <= r_idx;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_FIN;
               end
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         if (w_adv) begin
            if (r_idx == LAST_IDX) begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_FIN;
            end else begin
               r_idx   <= r_idx + IDX_W'(1);
               r_state <= S_ISSUE;
            end
         end
      end
   end

   assign ram_addr      = r_ram_addr;
   assign ram_rd        = r_ram_rd;
   assign busy          = r_busy;
   assign done          = r_done;
   assign collision     = r_coll;
   assign out_of_bounds = r_oob;
   assign hit_index     = r_hit;

endmodule

// File: tb/tb_piece_collision.sv
// Bench for piece_collision: two instances (RAM latency 1 and 3) share stimulus and are checked
// every cycle against a cell-walking timeline model, plus literal expectations for known pieces.
module tb_piece_collision;

   localparam int NC = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [7:0]  base_x;
   logic [6:0]  base_y;
   logic [15:0] offsets;
   logic [3:0]  cell_en;

   logic [5:0]  ram_q [2];
   logic [7:0]  ram_addr [2];
   logic        ram_rd [2];
   logic        busy [2];
   logic        done [2];
   logic        collision [2];
   logic        out_of_bounds [2];
   logic [1:0]  hit_index [2];

   always #5 clk = ~clk;

   piece_collision #(.RAM_LAT(1)) u_lat1 (
      .clk(clk), .resetn(resetn), .start(start), .base_x(base_x), .base_y(base_y),
      .offsets(offsets), .cell_en(cell_en), .ram_q(ram_q[0]), .ram_addr(ram_addr[0]),
      .ram_rd(ram_rd[0]), .busy(busy[0]), .done(done[0]), .collision(collision[0]),
      .out_of_bounds(out_of_bounds[0]), .hit_index(hit_index[0]));

   piece_collision #(.RAM_LAT(3)) u_lat3 (
      .clk(clk), .resetn(resetn), .start(start), .base_x(base_x), .base_y(base_y),
      .offsets(offsets), .cell_en(cell_en), .ram_q(ram_q[1]), .ram_addr(ram_addr[1]),
      .ram_rd(ram_rd[1]), .busy(busy[1]), .done(done[1]), .collision(collision[1]),
      .out_of_bounds(out_of_bounds[1]), .hit_index(hit_index[1]));

   // Board RAM: data returned only for strobed reads, after 1 or 3 clock edges.
   logic [5:0] mem [256];
   logic [5:0] q1;
   logic [5:0] q3 [3];
   always @(posedge clk) begin
      q1    <= ram_rd[0] ? mem[ram_addr[0]] : 6'h0;
      q3[0] <= ram_rd[1] ? mem[ram_addr[1]] : 6'h0;
      q3[1] <= q3[0];
      q3[2] <= q3[1];
   end
   assign ram_q[0] = q1;
   assign ram_q[1] = q3[2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit active = 1'b0;

   logic [7:0]  t_bx;
   logic [6:0]  t_by;
   logic [15:0] t_off;
   logic [3:0]  t_en;
   int  exp_done [2];
   bit  exp_rd [2][64];
   int  exp_ad [2][64];
   int  exp_coll, exp_oob, exp_hit;

   int  n_done [2];
   int  done_cyc [2];
   int  rda0[$], rda1[$], rdc0[$], rdc1[$];

   task automatic chk(input string nm, input int d, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, d, cyc, got, want);
      end
   endtask

   // Timeline model: cycle 1 is the first cycle after the start edge. A disabled or off-board
   // cell costs one cycle, an on-board cell is read in its first cycle and judged lat cycles later.
   task automatic build(input int d, input int lat);
      int t, cx, cy, a;
      bit fin;
      for (int c = 0; c < 64; c++) begin
         exp_rd[d][c] = 1'b0;
         exp_ad[d][c] = 0;
      end
      exp_coll = 0; exp_oob = 0; exp_hit = 0;
      t = 1; fin = 1'b0;
      for (int i = 0; i < NC && !fin; i++) begin
         if (!t_en[i]) begin
            t++;
         end else begin
            cx = int'(t_bx) + int'(t_off[4*i +: 2]);
            cy = int'(t_by) + int'(t_off[4*i+2 +: 2]);
            if (cx >= 10 || cy >= 20) begin
               exp_coll = 1; exp_oob = 1; exp_hit = i;
               exp_done[d] = t + 1; fin = 1'b1;
            end else begin
               a = cy*10 + cx;
               exp_rd[d][t] = 1'b1;
               exp_ad[d][t] = a;
               if (mem[a] != 6'h0) begin
                  exp_coll = 1; exp_hit = i;
                  exp_done[d] = t + lat + 1; fin = 1'b1;
               end else begin
                  t += 1 + lat;
               end
            end
         end
      end
      if (!fin) exp_done[d] = t;
   endtask

   always @(negedge clk) begin
      if (active) begin
         cyc++;
         for (int d = 0; d < 2; d++) begin
            chk("ram_rd", d, ram_rd[d], exp_rd[d][cyc]);
            if (exp_rd[d][cyc]) chk("ram_addr", d, ram_addr[d], exp_ad[d][cyc]);
            chk("busy", d, busy[d], cyc < exp_done[d]);
            chk("done", d, done[d], cyc == exp_done[d]);
            chk("collision", d, collision[d], (cyc >= exp_done[d]) ? exp_coll : 0);
            chk("out_of_bounds", d, out_of_bounds[d], (cyc >= exp_done[d]) ? exp_oob : 0);
            chk("hit_index", d, hit_index[d], (cyc >= exp_done[d]) ? exp_hit : 0);
            if (ram_rd[d]) begin
               if (d == 0) begin rda0.push_back(ram_addr[d]); rdc0.push_back(cyc); end
               else        begin rda1.push_back(ram_addr[d]); rdc1.push_back(cyc); end
            end
            if (done[d]) begin
               n_done[d]++;
               if (n_done[d] == 1) done_cyc[d] = cyc;
            end
         end
      end
   end

   task automatic run(input logic [7:0] bx, input logic [6:0] by, input logic [15:0] off,
                      input logic [3:0] en, input bit poke);
      int maxd;
      bit pk;
      t_bx = bx; t_by = by; t_off = off; t_en = en;
      build(0, 1);
      build(1, 3);
      maxd = (exp_done[1] > exp_done[0]) ? exp_done[1] : exp_done[0];
      pk = poke && (exp_done[0] >= 5);
      rda0.delete(); rda1.delete(); rdc0.delete(); rdc1.delete();
      n_done = '{0, 0};
      done_cyc = '{0, 0};
      @(negedge clk);
      base_x = bx; base_y = by; offsets = off; cell_en = en; start = 1'b1;
      @(posedge clk);
      cyc = 0;
      active = 1'b1;
      #1 start = 1'b0;
      for (int e = 1; e <= maxd + 2; e++) begin
         @(posedge clk);
         #1;
         // Extra starts: one mid-check with different inputs, one landing in the FIN cycle.
         if (pk && e == 2) begin
            start = 1'b1; base_x = 8'd0; base_y = 7'd0; offsets = 16'h0; cell_en = 4'hF;
         end
         if (pk && e == 3) start = 1'b0;
         if (pk && e == exp_done[0] - 1) start = 1'b1;
         if (pk && e == exp_done[0]) start = 1'b0;
      end
      active = 1'b0;
      for (int d = 0; d < 2; d++) chk("done_count", d, n_done[d], 1);
   endtask

   task automatic chk_outputs_zero(input string nm);
      for (int d = 0; d < 2; d++) begin
         chk({nm, "_addr"}, d, ram_addr[d], 0);
         chk({nm, "_rd"}, d, ram_rd[d], 0);
         chk({nm, "_busy"}, d, busy[d], 0);
         chk({nm, "_done"}, d, done[d], 0);
         chk({nm, "_coll"}, d, collision[d], 0);
         chk({nm, "_oob"}, d, out_of_bounds[d], 0);
         chk({nm, "_hit"}, d, hit_index[d], 0);
      end
   endtask

   initial begin
      logic [7:0] rbx;
      logic [6:0] rby;
      int exp_a [4];
      int exp_c [4];
      resetn = 1'b0; start = 1'b0; base_x = '0; base_y = '0; offsets = '0; cell_en = '0;
      for (int a = 0; a < 256; a++) mem[a] = 6'h0;
      repeat (2) @(posedge clk);
      #1 chk_outputs_zero("reset");
      @(negedge clk) resetn = 1'b1;

      // Empty board, T-like piece at (3,5).
      run(8'd3, 7'd5, 16'h5210, 4'hF, 1'b0);
      exp_a = '{53, 54, 55, 64};
      chk("c1_done_cycle", 0, done_cyc[0], 9);
      chk("c1_nreads", 0, rda0.size(), 4);
      if (rda0.size() == 4) for (int k = 0; k < 4; k++) chk("c1_addr", 0, rda0[k], exp_a[k]);
      chk("c1_coll", 0, collision[0], 0);
      exp_c = '{1, 5, 9, 13};
      chk("lat3_nreads", 1, rdc1.size(), 4);
      if (rdc1.size() == 4) for (int k = 0; k < 4; k++) chk("lat3_read_cycle", 1, rdc1[k], exp_c[k]);

      mem[64] = 6'h2A;
      run(8'd3, 7'd5, 16'h5210, 4'hF, 1'b0);
      chk("c2_nreads", 0, rda0.size(), 4);
      chk("c2_coll", 0, collision[0], 1);
      chk("c2_oob", 0, out_of_bounds[0], 0);
      chk("c2_hit", 0, hit_index[0], 3);
      mem[64] = 6'h0;

      run(8'd8, 7'd0, 16'h3210, 4'hF, 1'b0);
      chk("c3_nreads", 0, rda0.size(), 2);
      if (rda0.size() == 2) begin
         chk("c3_addr0", 0, rda0[0], 8);
         chk("c3_addr1", 0, rda0[1], 9);
      end
      chk("c3_coll", 0, collision[0], 1);
      chk("c3_oob", 0, out_of_bounds[0], 1);
      chk("c3_hit", 0, hit_index[0], 2);

      run(8'd0, 7'd18, 16'h000C, 4'hF, 1'b0);
      chk("c4a_nreads", 0, rda0.size(), 0);
      chk("c4a_oob", 0, out_of_bounds[0], 1);
      chk("c4a_hit", 0, hit_index[0], 0);
      run(8'd255, 7'd0, 16'h0000, 4'hF, 1'b0);
      chk("c4b_nreads", 0, rda0.size(), 0);
      chk("c4b_oob", 0, out_of_bounds[0], 1);
      chk("c4b_hit", 0, hit_index[0], 0);

      mem[54] = 6'h11;
      run(8'd3, 7'd5, 16'h5210, 4'b0101, 1'b0);
      chk("c5_coll", 0, collision[0], 0);
      chk("c5_nreads", 0, rda0.size(), 2);
      if (rda0.size() == 2) chk("c5_addr1", 0, rda0[1], 55);
      mem[54] = 6'h0;

      run(8'd3, 7'd5, 16'h5210, 4'h0, 1'b0);
      chk("alloff_done_cycle", 0, done_cyc[0], 5);
      chk("alloff_done_cycle", 1, done_cyc[1], 5);

      run(8'd3, 7'd5, 16'h5210, 4'hF, 1'b1);
      chk("poke_done_cycle", 0, done_cyc[0], 9);

      // Reset pulsed while both instances sit in WAIT for cell 0.
      @(negedge clk);
      base_x = 8'd3; base_y = 7'd5; offsets = 16'h5210; cell_en = 4'hF; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #3 resetn = 1'b0;
      #1 chk_outputs_zero("midreset");
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      repeat (12) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk("postreset_done", d, done[d], 0);
            chk("postreset_busy", d, busy[d], 0);
         end
      end

      for (int n = 0; n < 40; n++) begin
         for (int a = 0; a < 200; a++)
            mem[a] = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(1, 63)) : 6'h0;
         rbx = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom_range(0, 11));
         rby = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 21));
         run(rbx, rby, 16'($urandom), 4'($urandom), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/piece_collision.md
Name: piece_collision

Overview:
- Sequential collision checker for a whole tetromino against the board colour RAM.
- On `start`, captures a base coordinate and NUM_CELLS packed cell offsets. For each cell it checks board bounds, reads the RAM word at that cell and tests it for non-black. It then reports collision, out-of-bounds and the first offending cell index.
- Sits between the game-control FSM and the shared board RAM port. The RAM write signal is held low by the arbiter while `busy` is high.

Parameters:
- BOARD_W, 10, board columns; legal cx range 0..BOARD_W-1.
- BOARD_H, 20, board rows; legal cy range 0..BOARD_H-1.
- X_W, 8, width of base X.
- Y_W, 7, width of base Y.
- OFF_W, 2, width of each unsigned dx/dy offset (4x4 bounding box).
- NUM_CELLS, 4, cells per piece.
- ADDR_W, 8, RAM address width; BOARD_W*BOARD_H must be <= 2^ADDR_W.
- COLOUR_W, 6, RAM word width; value 0 means empty (black).
- RAM_LAT, 1, cycles from `ram_rd` and address to valid `ram_q` (>=1).

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- start  in  1  request pulse; accepted only in IDLE
- base_x  in  X_W  piece origin column
- base_y  in  Y_W  piece origin row
- offsets  in  NUM_CELLS*2*OFF_W  cell i occupies bits [i*2*OFF_W +: 2*OFF_W], dx in the low half, dy in the high half
- cell_en  in  NUM_CELLS  per-cell enable; a disabled cell is skipped
- ram_q  in  COLOUR_W  RAM read data
- ram_addr  out  ADDR_W  RAM read address
- ram_rd  out  1  read strobe
- busy  out  1  check in progress
- done  out  1  one-cycle completion pulse
- collision  out  1  piece overlaps an occupied cell or leaves the board
- out_of_bounds  out  1  collision was caused by bounds
- hit_index  out  clog2(NUM_CELLS)  index of the first offending cell

Behaviour:
- One clock, `clk`; reset `resetn` is asynchronous and active-low.
- Reset values: every output is 0; FSM is in IDLE; all captured registers are 0.
- Reset asserted mid-operation: abort immediately, return to IDLE, no `done` pulse, results cleared.
- States and transitions:
  - IDLE: `start`=1 at an edge latches all inputs, sets i=0, clears results and moves to ISSUE. `busy` goes 1 from the next cycle.
  - ISSUE:
    - Compute cx = base_x + dx_i and cy = base_y + dy_i, each one bit wider than its operand (no wrap).
    - If cell_en[i]=0: advance.
    - Else if cx>=BOARD_W or cy>=BOARD_H: set collision=1, out_of_bounds=1, hit_index=i; go to FIN. No RAM access.
    - Else: ram_addr = cy*BOARD_W + cx, truncated to ADDR_W; ram_rd=1 for this cycle only; go to WAIT.
  - WAIT: hold for RAM_LAT cycles, keeping ram_addr stable. In the last WAIT cycle `ram_q` is valid and is evaluated.
    - If any bit of `ram_q` is set: collision=1, hit_index=i, go to FIN.
    - Otherwise advance.
  - Advance: if i==NUM_CELLS-1 go to FIN, else i+1 and go to ISSUE.
  - FIN: done=1 for exactly one cycle; busy=0 in that cycle; go to IDLE.
- Early termination: stop at the first offending cell, in ascending index order. Later cells are not read.
- Result outputs hold until the next accepted `start`.
- `start` while busy or in FIN is ignored; it is not queued.
- ram_addr keeps its last value when idle. ram_rd is never high outside ISSUE.
- Latency:
  - Each enabled in-bounds cell costs 1+RAM_LAT cycles.
  - Each disabled or out-of-bounds cell costs 1 cycle.
  - `done` follows the final evaluation by 1 cycle.
- All cells disabled: NUM_CELLS ISSUE cycles, then `done` with collision=0.

Test Plan:
- Empty RAM, base (3,5), offsets (0,0)(1,0)(2,0)(1,1), all enabled, RAM_LAT=1:
  - reads addrs 53,54,55,64 in order;
  - `done` appears 9 cycles after the `start` edge;
  - collision=0.
- RAM[64]=6'h2A, same piece:
  - reads stop after addr 64;
  - collision=1, out_of_bounds=0, hit_index=3.
- base (8,0), offsets (0,0)(1,0)(2,0)(3,0):
  - reads addrs 8,9, then cell 2 has cx=10;
  - collision=1, out_of_bounds=1, hit_index=2;
  - no third ram_rd.
- base (0,18), dy=3 on cell 0, X_W edge base_x=255 on a second run:
  - both runs give out_of_bounds=1, hit_index=0 and zero RAM reads;
  - cx/cy do not wrap.
- cell_en=4'b0101, RAM[addr of cell 1]=nonzero:
  - cell 1 is skipped;
  - collision=0 and exactly 2 ram_rd pulses occur.
- Control corner cases:
  - `start` pulsed again while busy: ignored, a single `done`.
  - resetn pulsed low during WAIT: all outputs 0 asynchronously, no `done`.
  - RAM_LAT=3 build: 4 reads spaced 4 cycles apart.
